// File: rtl/bep_frame_sequencer.sv
// Thermostat bus frame sequencer: preamble hunt, 160-bit field capture, valid/ready hold.
// Optional constant-field check is built when BEP_CONSTANT_CHECK_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// HUNT    | shifting bits into the 32-bit window, looking for PREAMBLE
// RECEIVE | counting the 160 frame bits, steering them into field regs
// HOLD    | frame held for the consumer, incoming bits dropped
module bep_frame_sequencer #(
    parameter logic [31:0] PREAMBLE       = 32'hFFFF_FFFE,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] CONSTANT_VALUE = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [31:0] thermostat_id,
    output logic [15:0] room_temp,
    output logic [15:0] set_temp,
    output logic [7:0]  state,
    output logic        busy,
    output logic        frame_error,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_RECEIVE = 2'd1,
        S_HOLD    = 2'd2
    } fsm_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    fsm_t        fsm_q, fsm_d;
    logic [31:0] window_q;
    logic [7:0]  bit_cnt_q;
    logic [15:0] to_cnt_q;
    logic [31:0] id_q;
    logic [15:0] room_q;
    logic [15:0] set_q;
    logic [7:0]  state_q;
    logic        frame_error_q;
    logic [7:0]  frame_count_q;

    logic [31:0] window_next;
    logic        preamble_hit;
    logic        last_bit;
    logic        timed_out;
    logic        const_bad;

    assign window_next  = {window_q[30:0], bit_in};
    assign preamble_hit = bit_valid && (window_next == PREAMBLE);
    assign last_bit     = bit_valid && (bit_cnt_q == 8'd159);
    assign timed_out    = !bit_valid && (to_cnt_q == TO_LAST);

`ifdef BEP_CONSTANT_CHECK_EN
    logic [31:0] const_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            const_q <= '0;
        end else if (fsm_q == S_RECEIVE && bit_valid &&
                     bit_cnt_q >= 8'd32 && bit_cnt_q < 8'd64) begin
            const_q <= {const_q[30:0], bit_in};
        end
    end

    assign const_bad = (const_q != CONSTANT_VALUE);
`else
    localparam logic [31:0] unused_constant_value = CONSTANT_VALUE;
    assign const_bad = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q <= S_HUNT;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_HUNT: begin
                if (preamble_hit) fsm_d = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (last_bit) begin
                    fsm_d = const_bad ? S_HUNT : S_HOLD;
                end else if (timed_out) begin
                    fsm_d = S_HUNT;
                end
            end
            S_HOLD: begin
                if (frame_ready) fsm_d = S_HUNT;
            end
            default: fsm_d = S_HUNT;
        endcase
    end

    always_comb begin
        busy        = (fsm_q == S_RECEIVE);
        frame_valid = (fsm_q == S_HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            window_q      <= '0;
            bit_cnt_q     <= '0;
            to_cnt_q      <= '0;
            id_q          <= '0;
            room_q        <= '0;
            set_q         <= '0;
            state_q       <= '0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_error_q <= 1'b0;
            case (fsm_q)
                S_HUNT: begin
                    if (preamble_hit) begin
                        window_q  <= '0;
                        bit_cnt_q <= '0;
                        to_cnt_q  <= '0;
                    end else if (bit_valid) begin
                        window_q <= window_next;
                    end
                end
                S_RECEIVE: begin
                    if (bit_valid) begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                        to_cnt_q  <= '0;
                        if (bit_cnt_q >= 8'd64 && bit_cnt_q < 8'd96)
                            id_q <= {id_q[30:0], bit_in};
                        if (bit_cnt_q >= 8'd96 && bit_cnt_q < 8'd112)
                            room_q <= {room_q[14:0], bit_in};
                        if (bit_cnt_q >= 8'd112 && bit_cnt_q < 8'd128)
                            set_q <= {set_q[14:0], bit_in};
                        if (bit_cnt_q >= 8'd128 && bit_cnt_q < 8'd136)
                            state_q <= {state_q[6:0], bit_in};
                        if (last_bit) begin
                            if (const_bad) frame_error_q <= 1'b1;
                            else           frame_count_q <= frame_count_q + 8'd1;
                        end
                    end else if (timed_out) begin
                        frame_error_q <= 1'b1;
                        window_q      <= '0;
                        to_cnt_q      <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (frame_ready) window_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign thermostat_id = id_q;
    assign room_temp     = room_q;
    assign set_temp      = set_q;
    assign state         = state_q;
    assign frame_error   = frame_error_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_bep_frame_sequencer.sv
// Self-checking bench for bep_frame_sequencer: vector table, directed frames and
// random streams checked against a frame-level reference model.
module tb_bep_frame_sequencer;

    localparam logic [31:0] PRE    = 32'hFFFF_FFFE;
    localparam int          TO     = 20;
    localparam logic [31:0] CONSTV = 32'h0000_0000;
`ifdef BEP_CONSTANT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, bit_in, bit_valid, frame_ready;
    logic        frame_valid, busy, frame_error;
    logic [31:0] thermostat_id;
    logic [15:0] room_temp, set_temp;
    logic [7:0]  state, frame_count;

    always #5 clock = ~clock;

    bep_frame_sequencer #(
        .PREAMBLE(PRE), .TIMEOUT_CYCLES(TO), .CONSTANT_VALUE(CONSTV)
    ) dut (
        .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_ready(frame_ready), .frame_valid(frame_valid),
        .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp),
        .state(state), .busy(busy), .frame_error(frame_error), .frame_count(frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame-level view (collected bit list, idle-cycle count).
    bit          m_recv, m_hold, m_fk;
    logic [31:0] m_win;
    int          m_idle;
    bit          m_q[$];
    bit          e_err;
    logic [7:0]  e_cnt;
    logic [31:0] e_id;
    logic [15:0] e_rt, e_st;
    logic [7:0]  e_state;

    function automatic logic [31:0] take(input int lo, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 1) | 32'(m_q[lo + i]);
        return v;
    endfunction

    task automatic model_edge(input bit bv, input bit b, input bit rdy, input bit rst);
        bit ok;
        e_err = 1'b0;
        if (rst) begin
            m_recv = 0; m_hold = 0; m_win = '0; m_idle = 0; m_q.delete();
            e_cnt = '0; e_id = '0; e_rt = '0; e_st = '0; e_state = '0; m_fk = 1;
        end else if (m_hold) begin
            if (rdy) begin m_hold = 0; m_win = '0; end
        end else if (m_recv) begin
            if (bv) begin
                m_q.push_back(b);
                m_idle = 0;
                if (m_q.size() == 160) begin
                    m_recv = 0;
                    ok = 1'b1;
`ifdef BEP_CONSTANT_CHECK_EN
                    ok = (take(32, 32) == CONSTV);
`endif
                    if (!ok) begin
                        e_err = 1'b1;
                    end else begin
                        m_hold  = 1;
                        e_cnt   = e_cnt + 8'd1;
                        e_id    = take(64, 32);
                        e_rt    = 16'(take(96, 16));
                        e_st    = 16'(take(112, 16));
                        e_state = 8'(take(128, 8));
                        m_fk    = 1;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin e_err = 1'b1; m_recv = 0; m_win = '0; end
            end
        end else if (bv) begin
            m_win = {m_win[30:0], b};
            if (m_win == PRE) begin
                m_recv = 1; m_win = '0; m_idle = 0; m_q.delete(); m_fk = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("frame_valid", 32'(frame_valid), 32'(m_hold));
        chk("busy", 32'(busy), 32'(m_recv));
        chk("frame_error", 32'(frame_error), 32'(e_err));
        chk("frame_count", 32'(frame_count), 32'(e_cnt));
        if (m_fk) begin
            chk("thermostat_id", thermostat_id, e_id);
            chk("room_temp", 32'(room_temp), 32'(e_rt));
            chk("set_temp", 32'(set_temp), 32'(e_st));
            chk("state", 32'(state), 32'(e_state));
        end
    endtask

    task automatic step(input bit bv, input bit b, input bit rdy, input bit rst);
        @(negedge clock);
        bit_valid = bv; bit_in = b; frame_ready = rdy; reset = rst;
        model_edge(bv, b, rdy, rst);
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 1'b0);
    endtask

    task automatic send_body(input logic [31:0] cst, input logic [31:0] id,
                             input logic [15:0] rt, input logic [15:0] st,
                             input logic [7:0] sv);
        send_bits($urandom, 32);
        send_bits(cst, 32);
        send_bits(id, 32);
        send_bits(32'(rt), 16);
        send_bits(32'(st), 16);
        send_bits(32'(sv), 8);
        send_bits($urandom, 24);
    endtask

    task automatic send_frame(input logic [31:0] cst, input logic [31:0] id,
                              input logic [15:0] rt, input logic [15:0] st,
                              input logic [7:0] sv);
        send_bits(PRE, 32);
        send_body(cst, id, rt, st, sv);
    endtask

    typedef struct {
        bit         rst, bv, b, rdy;
        bit         e_busy, e_fv, e_err;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[7];
    int   nb, gap;
    logic [31:0] near[3];

    initial begin
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; frame_ready = 1'b0;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 8'd0};
        tbl[1] = '{1, 1, 1, 1, 0, 0, 0, 8'd0};
        tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 8'd0};
        tbl[3] = '{0, 1, 1, 0, 0, 0, 0, 8'd0};
        tbl[4] = '{0, 1, 0, 1, 0, 0, 0, 8'd0};
        tbl[5] = '{0, 0, 1, 1, 0, 0, 0, 8'd0};
        tbl[6] = '{1, 0, 0, 0, 0, 0, 0, 8'd0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].bv, tbl[i].b, tbl[i].rdy, tbl[i].rst);
            chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("tbl_fv", 32'(frame_valid), 32'(tbl[i].e_fv));
            chk("tbl_err", 32'(frame_error), 32'(tbl[i].e_err));
            chk("tbl_cnt", 32'(frame_count), 32'(tbl[i].e_cnt));
        end

        // Basic frame, then hold with ready low
        send_frame(CONSTV, 32'h1234_5678, 16'h00D2, 16'h00C8, 8'h03);
        chk("t1_fv", 32'(frame_valid), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_cnt", 32'(frame_count), 32'd1);
        chk("t1_id", thermostat_id, 32'h1234_5678);
        chk("t1_rt", 32'(room_temp), 32'h00D2);
        chk("t1_st", 32'(set_temp), 32'h00C8);
        chk("t1_state", 32'(state), 32'h03);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_hold_fv", 32'(frame_valid), 32'd1);
        chk("t1_hold_id", thermostat_id, 32'h1234_5678);

        // Bits during HOLD are dropped, including one on the release edge
        send_bits(PRE, 32);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_fv_drop", 32'(frame_valid), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        send_frame(CONSTV, 32'hCAFE_0042, 16'h0101, 16'h0202, 8'h5A);
        chk("t2_id", thermostat_id, 32'hCAFE_0042);
        chk("t2_cnt", 32'(frame_count), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Line-idle timeout after 40 body bits
        send_bits(PRE, 32);
        send_bits($urandom, 32);
        send_bits($urandom, 8);
        repeat (TO) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_err", 32'(frame_error), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_fv", 32'(frame_valid), 32'd0);
        chk("t3_cnt", 32'(frame_count), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_err_clr", 32'(frame_error), 32'd0);
        send_frame(CONSTV, 32'h0BAD_F00D, 16'h7FFF, 16'h8000, 8'hFF);
        chk("t3_cnt_after", 32'(frame_count), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Near-miss preambles must not start a frame
        send_bits($urandom, 32);
        send_bits($urandom, 18);
        near[0] = 32'h7FFF_FFFE; near[1] = 32'hFFFF_7FFE; near[2] = 32'hEFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            send_bits(32'h0, 8);
            send_bits(near[i], 32);
            chk("t4_near_busy", 32'(busy), 32'd0);
        end
        send_bits(32'h0, 8);
        send_bits(32'hFFFF_FFFF, 31);
        chk("t4_pre_busy", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_recv_busy", 32'(busy), 32'd1);
        send_body(CONSTV, 32'h0000_0001, 16'h0002, 16'h0003, 8'h04);
        chk("t4_id", thermostat_id, 32'h0000_0001);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Random stream: gaps, timeouts, partial frames, random ready
        for (int it = 0; it < 40; it++) begin
            for (int g = 0; g < 50 && m_hold; g++)
                step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
            send_bits(PRE, 32);
            nb = $urandom_range(0, 175);
            for (int k = 0; k < nb; k++) begin
                gap = ($urandom_range(0, 39) == 0) ? TO + 2 : $urandom_range(0, 3);
                repeat (gap) step(1'b0, 1'b0, 1'($urandom), 1'b0);
                step(1'b1, 1'($urandom), 1'($urandom), 1'b0);
            end
        end

        // 256 deliveries wrap frame_count; then reset mid-frame
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 256; f++) begin
            send_frame(CONSTV, $urandom, 16'($urandom), 16'($urandom), 8'($urandom));
            if (f == 254) chk("t5_cnt_255", 32'(frame_count), 32'd255);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("t5_wrap", 32'(frame_count), 32'd0);
        send_frame(CONSTV, 32'h1111_2222, 16'h3333, 16'h4444, 8'h55);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(PRE, 32);
        send_body(CONSTV, 32'hFFFF_FFFF, 16'h0, 16'h0, 8'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(PRE, 32);
        send_bits($urandom, 32);
        send_bits($urandom, 32);
        send_bits(32'hFFFF_FFFF, 16);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_fv", 32'(frame_valid), 32'd0);
        chk("t5_rst_err", 32'(frame_error), 32'd0);
        chk("t5_rst_cnt", 32'(frame_count), 32'd0);
        chk("t5_rst_id", thermostat_id, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_rst_err2", 32'(frame_error), 32'd0);

        // Constant field 1: rejected only with the check built in
        send_frame(32'h0000_0001, 32'hABCD_EF01, 16'h0010, 16'h0020, 8'h01);
        chk("t6_fv", 32'(frame_valid), 32'(!CHK_EN));
        chk("t6_err", 32'(frame_error), 32'(CHK_EN));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(32'h0000_0000, 32'h5555_AAAA, 16'h0011, 16'h0022, 8'h02);
        chk("t6_ok_fv", 32'(frame_valid), 32'd1);
        chk("t6_ok_id", thermostat_id, 32'h5555_AAAA);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
